// File: rtl/score_display.sv
// Dinosaur-game score keeper: 4-digit BCD tick counter plus a serial driver
// that shifts a 64-bit seven-segment frame out to the board's SEGLED display.
module score_display #(
  parameter int CLK_DIV = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        game_clk,
  input  logic        start,
  input  logic        game_over,
  output logic [15:0] score,
  output logic        seg_clk,
  output logic        seg_do,
  output logic        seg_pen,
  output logic        seg_clr,
  output logic        busy
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] LOAD  = 2'd1;
  localparam logic [1:0] SHIFT = 2'd2;
  localparam logic [1:0] LATCH = 2'd3;

  localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);

  function automatic logic [7:0] seg7(input logic [3:0] d);
    case (d)
      4'd0:    seg7 = 8'hC0;
      4'd1:    seg7 = 8'hF9;
      4'd2:    seg7 = 8'hA4;
      4'd3:    seg7 = 8'hB0;
      4'd4:    seg7 = 8'h99;
      4'd5:    seg7 = 8'h92;
      4'd6:    seg7 = 8'h82;
      4'd7:    seg7 = 8'hF8;
      4'd8:    seg7 = 8'h80;
      4'd9:    seg7 = 8'h90;
      default: seg7 = 8'hFF;
    endcase
  endfunction

  function automatic logic [15:0] bcd_inc(input logic [15:0] v);
    logic [15:0] r;
    logic        c;
    r = v;
    c = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (c) begin
        if (v[i*4 +: 4] >= 4'd9) begin
          r[i*4 +: 4] = 4'd0;
        end else begin
          r[i*4 +: 4] = v[i*4 +: 4] + 4'd1;
          c = 1'b0;
        end
      end
    end
    return r;
  endfunction

  logic        game_clk_q, start_q;
  logic        running_q, running_d;
  logic [15:0] score_q, score_d;
  logic [1:0]  state_q, state_d;
  logic [15:0] shown_q, shown_d;
  logic        pending_init_q, pending_init_d;
  logic [63:0] frame_q, frame_d;
  logic [5:0]  bit_cnt_q, bit_cnt_d;
  logic [7:0]  div_q, div_d;
  logic        phase_q, phase_d;
  logic        seg_clk_q, seg_clk_d;
  logic        seg_pen_q, seg_pen_d;
  logic        busy_q, busy_d;
  logic        seg_clr_q;
  logic        tick, start_edge;

  assign tick       = game_clk & ~game_clk_q;
  assign start_edge = start & ~start_q;

  always_comb begin
    running_d = start_edge ? 1'b1 : running_q;
    score_d   = score_q;
    if (game_over) running_d = 1'b0;
    // A fresh run's clear takes priority over a coincident tick.
    if (start_edge) score_d = 16'h0000;
    else if (tick && running_q && !game_over) score_d = bcd_inc(score_q);
  end

  always_comb begin
    state_d        = state_q;
    shown_d        = shown_q;
    pending_init_d = pending_init_q;
    frame_d        = frame_q;
    bit_cnt_d      = bit_cnt_q;
    div_d          = div_q;
    phase_d        = phase_q;
    seg_clk_d      = seg_clk_q;
    seg_pen_d      = seg_pen_q;
    busy_d         = busy_q;
    case (state_q)
      IDLE: if (score_q != shown_q || pending_init_q) state_d = LOAD;
      LOAD: begin
        shown_d        = score_q;
        frame_d        = {32'hFFFF_FFFF, seg7(score_q[15:12]), seg7(score_q[11:8]),
                          seg7(score_q[7:4]), seg7(score_q[3:0])};
        pending_init_d = 1'b0;
        seg_pen_d      = 1'b0;
        busy_d         = 1'b1;
        seg_clk_d      = 1'b0;
        bit_cnt_d      = 6'd0;
        div_d          = 8'd0;
        phase_d        = 1'b0;
        state_d        = SHIFT;
      end
      SHIFT: begin
        if (div_q == DIV_LAST) begin
          div_d = 8'd0;
          if (!phase_q) begin
            phase_d   = 1'b1;
            seg_clk_d = 1'b1;
          end else if (bit_cnt_q == 6'd63) begin
            seg_clk_d = 1'b0;
            seg_pen_d = 1'b1;
            busy_d    = 1'b0;
            state_d   = LATCH;
          end else begin
            // Falling edge: next bit moves onto seg_do (frame MSB).
            phase_d   = 1'b0;
            seg_clk_d = 1'b0;
            frame_d   = {frame_q[62:0], 1'b0};
            bit_cnt_d = bit_cnt_q + 6'd1;
          end
        end else begin
          div_d = div_q + 8'd1;
        end
      end
      LATCH: begin
        frame_d = 64'd0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      game_clk_q     <= 1'b0;
      start_q        <= 1'b0;
      running_q      <= 1'b0;
      score_q        <= 16'h0000;
      state_q        <= IDLE;
      shown_q        <= 16'h0000;
      pending_init_q <= 1'b1;
      frame_q        <= 64'd0;
      bit_cnt_q      <= 6'd0;
      div_q          <= 8'd0;
      phase_q        <= 1'b0;
      seg_clk_q      <= 1'b0;
      seg_pen_q      <= 1'b1;
      busy_q         <= 1'b0;
      seg_clr_q      <= 1'b0;
    end else begin
      game_clk_q     <= game_clk;
      start_q        <= start;
      running_q      <= running_d;
      score_q        <= score_d;
      state_q        <= state_d;
      shown_q        <= shown_d;
      pending_init_q <= pending_init_d;
      frame_q        <= frame_d;
      bit_cnt_q      <= bit_cnt_d;
      div_q          <= div_d;
      phase_q        <= phase_d;
      seg_clk_q      <= seg_clk_d;
      seg_pen_q      <= seg_pen_d;
      busy_q         <= busy_d;
      seg_clr_q      <= 1'b1;
    end
  end

  assign score   = score_q;
  assign seg_clk = seg_clk_q;
  assign seg_do  = frame_q[63];
  assign seg_pen = seg_pen_q;
  assign seg_clr = seg_clr_q;
  assign busy    = busy_q;

endmodule

// File: tb/tb_score_display.sv
// Bench for score_display: directed tick/start/game_over sequences; a monitor
// reassembles each shifted frame and checks it against queued expected frames.
module tb_score_display;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        game_clk = 1'b0;
  logic        start = 1'b0;
  logic        game_over = 1'b0;
  logic [15:0] score;
  logic        seg_clk, seg_do, seg_pen, seg_clr, busy;

  int checks = 0;
  int failures = 0;

  logic [63:0] exp_q[$];
  int          mon_bits = 0;
  logic [63:0] mon_frame = '0;
  int          mon_pen_low = 0;

  score_display #(.CLK_DIV(2)) dut (
    .clk(clk), .rst(rst), .game_clk(game_clk), .start(start),
    .game_over(game_over), .score(score), .seg_clk(seg_clk),
    .seg_do(seg_do), .seg_pen(seg_pen), .seg_clr(seg_clr), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] seg_of(input logic [3:0] d);
    case (d)
      4'd0: return 8'hC0;  4'd1: return 8'hF9;  4'd2: return 8'hA4;
      4'd3: return 8'hB0;  4'd4: return 8'h99;  4'd5: return 8'h92;
      4'd6: return 8'h82;  4'd7: return 8'hF8;  4'd8: return 8'h80;
      4'd9: return 8'h90;  default: return 8'hFF;
    endcase
  endfunction

  function automatic logic [63:0] exp_frame(input logic [15:0] s);
    logic [63:0] f;
    f[63:32] = 32'hFFFF_FFFF;
    for (int i = 0; i < 4; i++) f[i*8 +: 8] = seg_of(s[i*4 +: 4]);
    return f;
  endfunction

  // Driver tasks
  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1 game_clk = 1'b1;
      @(posedge clk); #1 game_clk = 1'b0;
    end
  endtask

  task automatic start_pulse();
    @(posedge clk); #1 start = 1'b0;
    @(posedge clk); #1 start = 1'b1;
  endtask

  task automatic quiesce();
    int idle_n = 0;
    int n = 0;
    while (idle_n < 12 && n < 3000) begin
      @(negedge clk);
      n++;
      if (!busy) idle_n++;
      else idle_n = 0;
    end
    chk("quiesce_timeout", 64'(idle_n >= 12), 64'd1);
  endtask

  // Monitor: rebuild frame from seg_clk rising edges, compare on seg_pen rise
  initial begin
    logic prev_clk;
    logic prev_pen;
    logic [63:0] e;
    prev_clk = 1'b0;
    prev_pen = 1'b1;
    forever begin
      @(negedge clk);
      if (rst) begin
        mon_bits = 0; mon_frame = '0; mon_pen_low = 0;
        prev_clk = 1'b0; prev_pen = 1'b1;
      end else begin
        if (seg_clk && !prev_clk) begin
          mon_frame = {mon_frame[62:0], seg_do};
          mon_bits++;
        end
        if (!seg_pen) mon_pen_low++;
        if (seg_pen && !prev_pen) begin
          if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("frame_data", mon_frame, e);
            chk("frame_bits", 64'(mon_bits), 64'd64);
            chk("frame_pen_low", 64'(mon_pen_low), 64'd256);
          end
          mon_bits = 0; mon_frame = '0; mon_pen_low = 0;
        end
        prev_clk = seg_clk;
        prev_pen = seg_pen;
      end
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    // Reset state and first frame
    exp_q.push_back(exp_frame(16'h0000));
    repeat (3) @(posedge clk);
    #1;
    chk("rst_score", 64'(score), 64'h0000);
    chk("rst_outs", 64'({seg_clk, seg_do, seg_pen, seg_clr, busy}), 64'b00100);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("seg_clr_release", 64'(seg_clr), 64'd1);
    quiesce();
    chk("first_frame_seen", 64'(exp_q.size()), 64'd0);
    ticks(1);
    quiesce();
    chk("idle_no_count", 64'(score), 64'h0000);

    // Run to 0012; last step checked as one frame
    start_pulse();
    ticks(11);
    quiesce();
    chk("score_0011", 64'(score), 64'h0011);
    exp_q.push_back(exp_frame(16'h0012));
    ticks(1);
    quiesce();
    chk("score_0012", 64'(score), 64'h0012);
    chk("frame_0012_seen", 64'(exp_q.size()), 64'd0);

    // Simultaneous start edge and tick at 0042
    @(posedge clk); #1 start = 1'b0;
    ticks(30);
    quiesce();
    chk("score_0042", 64'(score), 64'h0042);
    exp_q.push_back(exp_frame(16'h0000));
    @(posedge clk); #1 start = 1'b1; game_clk = 1'b1;
    @(posedge clk); #1 game_clk = 1'b0;
    quiesce();
    chk("clear_beats_tick", 64'(score), 64'h0000);

    // game_over freezes, restart resumes
    ticks(5);
    quiesce();
    chk("score_0005", 64'(score), 64'h0005);
    @(posedge clk); #1 game_over = 1'b1;
    ticks(10);
    quiesce();
    chk("frozen_0005", 64'(score), 64'h0005);
    @(posedge clk); #1 game_over = 1'b0;
    ticks(1);
    quiesce();
    chk("stopped_0005", 64'(score), 64'h0005);
    start_pulse();
    ticks(3);
    quiesce();
    chk("restart_0003", 64'(score), 64'h0003);

    // Wrap 9998 -> 9999 -> 0000 -> 0001
    ticks(9995);
    quiesce();
    chk("score_9998", 64'(score), 64'h9998);
    exp_q.push_back(exp_frame(16'h9999));
    ticks(1);
    quiesce();
    chk("score_9999", 64'(score), 64'h9999);
    exp_q.push_back(exp_frame(16'h0000));
    ticks(1);
    quiesce();
    chk("wrap_0000", 64'(score), 64'h0000);
    ticks(1);
    quiesce();
    chk("after_wrap_0001", 64'(score), 64'h0001);
    chk("wrap_frames_seen", 64'(exp_q.size()), 64'd0);

    // Reset during bit 30 of a frame
    ticks(1);
    n = 0;
    while (mon_bits < 30 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    chk("bit30_timeout", 64'(mon_bits >= 30), 64'd1);
    #1 rst = 1'b1;
    #1;
    chk("midrst_score", 64'(score), 64'h0000);
    chk("midrst_outs", 64'({seg_clk, seg_do, seg_pen, seg_clr, busy}), 64'b00100);
    exp_q.push_back(exp_frame(16'h0000));
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    quiesce();
    chk("post_rst_score", 64'(score), 64'h0000);
    chk("post_rst_frame_seen", 64'(exp_q.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
